// File: rtl/prompt_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// prompt_sequencer_pkg
// Shared definitions for the prompt sequencer: FSM state encoding, the 3-bit
// button codes presented to the button checker, and the LFSR step function.
// ----------------------------------------------------------------------------
package prompt_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GEN     = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  // Code 0 never reaches the checker; it only appears after reset.
  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_A     = 3'd1,
    BTN_B     = 3'd2,
    BTN_SEL   = 3'd3,
    BTN_UP    = 3'd4,
    BTN_DOWN  = 3'd5,
    BTN_LEFT  = 3'd6,
    BTN_RIGHT = 3'd7
  } btn_t;

  // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/prompt_lfsr.sv
// ----------------------------------------------------------------------------
// prompt_lfsr
// 8-bit Galois LFSR that supplies random button codes. Loads SEED on reset and
// advances one step per cycle while en_i is high.
//   clk     in   system clock
//   rst     in   synchronous active-low reset (loads SEED)
//   en_i    in   advance the LFSR this cycle
//   code_o  out  low three bits of the current LFSR value
// ----------------------------------------------------------------------------
module prompt_lfsr
  import prompt_sequencer_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [2:0] code_o
);

  logic [7:0] lfsr_q;

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values and process ordering cannot change the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign code_o = lfsr_q[2:0];

endmodule

// File: rtl/prompt_sequencer.sv
// ----------------------------------------------------------------------------
// prompt_sequencer
// Game controller: draws a random button prompt, enables the button checker,
// waits for a response or a timeout, and keeps score, lives and round count.
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   start        in   begin a new game from IDLE or OVER
//   chk_done     in   button checker finished
//   chk_correct  in   one-cycle pulse, one cycle before chk_done, on a hit
//   chk_en       out  enable to the button checker
//   chk_val      out  expected button code (1..7)
//   chk_rst_n    out  one-cycle active-low abort to the checker on timeout
//   score        out  correct responses this game (saturating)
//   lives        out  remaining lives
//   round        out  prompts issued this game (wraps)
//   busy         out  game in progress
//   game_over    out  game finished, final results held
// ----------------------------------------------------------------------------
module prompt_sequencer
  import prompt_sequencer_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000,
  parameter logic [1:0]  LIVES   = 2'd3,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       chk_done,
  input  logic       chk_correct,
  output logic       chk_en,
  output logic [2:0] chk_val,
  output logic       chk_rst_n,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [7:0] round,
  output logic       busy,
  output logic       game_over
);

  state_t      state_q, state_d;
  btn_t        chk_val_q, chk_val_d;
  logic        chk_en_q, chk_en_d;
  logic        chk_rst_n_q, chk_rst_n_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  round_q, round_d;
  logic        busy_q, busy_d;
  logic        over_q, over_d;
  logic        hit_q, hit_d;
  logic [31:0] cnt_q, cnt_d;

  logic        lfsr_en;
  logic [2:0]  lfsr_code;
  logic        timeout_hit;
  logic [1:0]  lives_dec;

  prompt_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (lfsr_en),
    .code_o (lfsr_code)
  );

  // cnt_q is 1 on the first WAIT cycle, so TIMEOUT-1 here lands the abort
  // pulse TIMEOUT cycles after ISSUE.
  assign timeout_hit = (cnt_q >= TIMEOUT - 32'd1);
  assign lives_dec   = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    chk_val_d   = chk_val_q;
    chk_rst_n_d = 1'b1;
    score_d     = score_q;
    lives_d     = lives_q;
    round_d     = round_q;
    hit_d       = hit_q;
    cnt_d       = cnt_q;
    lfsr_en     = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_GEN;
          score_d = 8'd0;
          round_d = 8'd0;
          lives_d = LIVES;
        end
      end
      S_GEN: begin
        lfsr_en = 1'b1;
        if (lfsr_code != 3'd0) begin
          chk_val_d = btn_t'(lfsr_code);
          state_d   = S_ISSUE;
          // Bumped on entry so the new round is visible while in ISSUE.
          round_d   = round_q + 8'd1;
          cnt_d     = 32'd0;
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_q + 32'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (chk_correct) hit_d = 1'b1;
        if (chk_done) begin
          // A correct pulse coincident with done still counts as a hit.
          if (hit_q || chk_correct) begin
            score_d = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
          end else begin
            lives_d = lives_dec;
          end
          hit_d   = 1'b0;
          state_d = S_RELEASE;
        end else if (timeout_hit) begin
          chk_rst_n_d = 1'b0;
          lives_d     = lives_dec;
          hit_d       = 1'b0;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        hit_d = 1'b0;
        if (!chk_done) state_d = (lives_q == 2'd0) ? S_OVER : S_GEN;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs derive from the next state so they change on entry.
    chk_en_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    busy_d   = (state_d != S_IDLE) && (state_d != S_OVER);
    over_d   = (state_d == S_OVER);
  end

  // NOTE: reset is synchronous and clears every register here; there is no
  // memory array, so nothing is left uninitialised by skipping a reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      chk_val_q   <= BTN_NONE;
      chk_en_q    <= 1'b0;
      chk_rst_n_q <= 1'b1;
      score_q     <= 8'd0;
      lives_q     <= 2'd0;
      round_q     <= 8'd0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
      hit_q       <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      chk_val_q   <= chk_val_d;
      chk_en_q    <= chk_en_d;
      chk_rst_n_q <= chk_rst_n_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      round_q     <= round_d;
      busy_q      <= busy_d;
      over_q      <= over_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign chk_en    = chk_en_q;
  assign chk_val   = chk_val_q;
  assign chk_rst_n = chk_rst_n_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign round     = round_q;
  assign busy      = busy_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_prompt_sequencer.sv
// ----------------------------------------------------------------------------
// tb_prompt_sequencer
// Self-checking bench for prompt_sequencer with TIMEOUT=16, LIVES=3.
// A behavioural checker model answers prompts; predicted prompt codes are
// queued from an independent LFSR model and popped when chk_en rises.
// ----------------------------------------------------------------------------
module tb_prompt_sequencer;

  localparam logic [31:0] TMO    = 32'd16;
  localparam logic [1:0]  NLIVES = 2'd3;
  localparam logic [7:0]  SEED_V = 8'hA5;

  typedef enum int {R_CORRECT, R_WRONG, R_SILENT} resp_e;

  typedef struct {
    bit         start;
    resp_e      resp;
    logic [7:0] score;
    logic [1:0] lives;
    logic [7:0] round;
    bit         over;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       chk_done = 1'b0;
  logic       chk_correct = 1'b0;
  logic       chk_en;
  logic [2:0] chk_val;
  logic       chk_rst_n;
  logic [7:0] score;
  logic [1:0] lives;
  logic [7:0] round;
  logic       busy;
  logic       game_over;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] lfsr_m;
  logic [2:0] exp_q[$];
  vec_t       vecs[12];

  always #5 clk = ~clk;

  prompt_sequencer #(.TIMEOUT(TMO), .LIVES(NLIVES), .SEED(SEED_V)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .chk_done    (chk_done),
    .chk_correct (chk_correct),
    .chk_en      (chk_en),
    .chk_val     (chk_val),
    .chk_rst_n   (chk_rst_n),
    .score       (score),
    .lives       (lives),
    .round       (round),
    .busy        (busy),
    .game_over   (game_over)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1, shifting toward bit 0.
  function automatic logic [7:0] m_step(input logic [7:0] v);
    logic [7:0] r;
    r = v >> 1;
    if (v[0]) begin
      r[7] = ~r[7];
      r[5] = ~r[5];
      r[4] = ~r[4];
      r[3] = ~r[3];
    end
    return r;
  endfunction

  task automatic push_prompt();
    while (lfsr_m[2:0] == 3'd0) lfsr_m = m_step(lfsr_m);
    exp_q.push_back(lfsr_m[2:0]);
    lfsr_m = m_step(lfsr_m);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_chk_en"},    chk_en, 0);
    check({tag, "_chk_val"},   chk_val, 0);
    check({tag, "_chk_rst_n"}, chk_rst_n, 1);
    check({tag, "_score"},     score, 0);
    check({tag, "_lives"},     lives, 0);
    check({tag, "_round"},     round, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",  busy, 1);
    check("start_over",  game_over, 0);
    check("start_score", score, 0);
    check("start_lives", lives, NLIVES);
    check("start_round", round, 0);
    push_prompt();
  endtask

  task automatic await_prompt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (chk_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL prompt_wait: chk_en got 0 for 40 cycles, expected 1");
    end
  endtask

  task automatic pop_compare();
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got prompt %0d, expected none queued", chk_val);
    end else begin
      e = exp_q.pop_front();
      check("chk_val", chk_val, e);
    end
  endtask

  // Returns one negedge after the DUT has left RELEASE.
  task automatic do_prompt(input resp_e r, input logic [7:0] exp_round);
    bit ok;
    int cyc;
    await_prompt(ok);
    if (!ok) return;
    pop_compare();
    check("round_at_issue", round, exp_round);
    check("busy_at_issue", busy, 1);
    @(negedge clk);
    check("chk_en_wait", chk_en, 1);
    if (r == R_CORRECT) begin
      chk_correct = 1'b1;
      @(negedge clk);
      chk_correct = 1'b0;
    end
    if (r != R_SILENT) begin
      chk_done = 1'b1;
      @(negedge clk);
      check("release_chk_en", chk_en, 0);
      check("release_chk_rst_n", chk_rst_n, 1);
      @(negedge clk);
      check("release_hold_chk_en", chk_en, 0);
      chk_done = 1'b0;
      @(negedge clk);
    end else begin
      cyc = 0;
      for (int k = 2; k <= 40; k++) begin
        @(negedge clk);
        if (chk_rst_n === 1'b0) begin
          cyc = k;
          break;
        end
      end
      check("abort_cycle", cyc, TMO);
      check("abort_chk_en", chk_en, 0);
      @(negedge clk);
      check("abort_width", chk_rst_n, 1);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    //              start  resp       score  lives round  over
    vecs[0]  = '{1'b1, R_CORRECT, 8'd1, 2'd3, 8'd1, 1'b0};
    vecs[1]  = '{1'b0, R_CORRECT, 8'd2, 2'd3, 8'd2, 1'b0};
    vecs[2]  = '{1'b0, R_WRONG,   8'd2, 2'd2, 8'd3, 1'b0};
    vecs[3]  = '{1'b0, R_SILENT,  8'd2, 2'd1, 8'd4, 1'b0};
    vecs[4]  = '{1'b0, R_WRONG,   8'd2, 2'd0, 8'd5, 1'b1};
    vecs[5]  = '{1'b1, R_WRONG,   8'd0, 2'd2, 8'd1, 1'b0};
    vecs[6]  = '{1'b0, R_WRONG,   8'd0, 2'd1, 8'd2, 1'b0};
    vecs[7]  = '{1'b0, R_CORRECT, 8'd1, 2'd1, 8'd3, 1'b0};
    vecs[8]  = '{1'b0, R_SILENT,  8'd1, 2'd0, 8'd4, 1'b1};
    vecs[9]  = '{1'b1, R_WRONG,   8'd0, 2'd2, 8'd1, 1'b0};
    vecs[10] = '{1'b0, R_WRONG,   8'd0, 2'd1, 8'd2, 1'b0};
    vecs[11] = '{1'b0, R_WRONG,   8'd0, 2'd0, 8'd3, 1'b1};

    lfsr_m = SEED_V;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Table of games
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].start) do_start();
      do_prompt(vecs[i].resp, vecs[i].round);
      check("vec_score", score, vecs[i].score);
      check("vec_lives", lives, vecs[i].lives);
      check("vec_round", round, vecs[i].round);
      check("vec_game_over", game_over, vecs[i].over);
      check("vec_busy", busy, !vecs[i].over);
      check("vec_chk_en", chk_en, 0);
      if (!vecs[i].over) push_prompt();
    end

    // Results hold in OVER
    repeat (5) @(negedge clk);
    check("over_hold_round", round, 3);
    check("over_hold_game_over", game_over, 1);

    // Reset while waiting for a response
    do_start();
    await_prompt(ok);
    if (ok) pop_compare();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_reset("midgame_reset");
    rst = 1'b1;
    lfsr_m = SEED_V;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_chk_rst_n", chk_rst_n, 1);

    // Score saturation and round wrap
    do_start();
    for (int n = 1; n <= 256; n++) begin
      do_prompt(R_CORRECT, 8'(n));
      check("sat_score", score, (n > 255) ? 255 : n);
      check("sat_lives", lives, NLIVES);
      push_prompt();
    end
    check("wrap_round", round, 0);
    check("final_score", score, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
